// File: rtl/operand_bypass_unit_pkg.sv
// Shared definitions for the operand bypass unit.
//  - Default operand and tag widths.
//  - Layout of one writeback-history entry, packed as {valid, tag, data}.
//    The data field sits at bit 0, the tag directly above it, and the valid
//    bit is the MSB.
package operand_bypass_unit_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 3;

    localparam int ENT_DATA_LSB = 0;

    function automatic int ent_tag_lsb(input int width);
        return width;
    endfunction

    function automatic int ent_valid_bit(input int width, input int addr_w);
        return width + addr_w;
    endfunction

    function automatic int ent_w(input int width, input int addr_w);
        return width + addr_w + 1;
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Operand bypass bus.
//  master : writeback port, per-channel read tags / register data /
//           immediates / mode bits, stall; receives operands and hit flags.
//  slave  : the bypass unit itself.
// Per-channel fields are packed with channel c at [c*W +: W].
interface operand_bypass_unit_if
    import operand_bypass_unit_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_CH = 2
);
    logic                      write_en;
    logic [ADDR_W-1:0]         write_addr;
    logic [WIDTH-1:0]          write_data;
    logic [NUM_CH*ADDR_W-1:0]  read_addr;
    logic [NUM_CH*WIDTH-1:0]   reg_data;
    logic [NUM_CH*WIDTH-1:0]   imm;
    logic [NUM_CH-1:0]         src_sel;
    logic [NUM_CH-1:0]         neg;
    logic                      stall;
    logic [NUM_CH*WIDTH-1:0]   operand;
    logic [NUM_CH-1:0]         fwd_hit;

    modport master (
        output write_en, write_addr, write_data, read_addr, reg_data,
               imm, src_sel, neg, stall,
        input  operand, fwd_hit
    );

    modport slave (
        input  write_en, write_addr, write_data, read_addr, reg_data,
               imm, src_sel, neg, stall,
        output operand, fwd_hit
    );
endinterface

// File: rtl/operand_bypass_unit_bypass_lookup.sv
// bypass_lookup: priority match of one read tag against the writeback history.
//  hist       in   DEPTH packed entries, entry 0 = youngest
//  write_*    in   writeback presented this cycle (used when SAME_CYC != 0)
//  tag        in   read tag of this channel
//  reg_data   in   register-file value, used when nothing matches
//  hit        out  1 = data came from the bypass path
//  data       out  selected value
module bypass_lookup
    import operand_bypass_unit_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int SAME_CYC = 1
) (
    input  logic [DEPTH*ent_w(WIDTH, ADDR_W)-1:0] hist,
    input  logic                                  write_en,
    input  logic [ADDR_W-1:0]                     write_addr,
    input  logic [WIDTH-1:0]                      write_data,
    input  logic [ADDR_W-1:0]                     tag,
    input  logic [WIDTH-1:0]                      reg_data,
    output logic                                  hit,
    output logic [WIDTH-1:0]                      data
);
    localparam int ENT_W   = ent_w(WIDTH, ADDR_W);
    localparam int TAG_LSB = ent_tag_lsb(WIDTH);
    localparam int V_BIT   = ent_valid_bit(WIDTH, ADDR_W);

    logic [DEPTH-1:0] match;
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic             same_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign match[gi]    = hist[gi*ENT_W + V_BIT] &&
                                  (hist[gi*ENT_W + TAG_LSB +: ADDR_W] == tag);
            assign ent_data[gi] = hist[gi*ENT_W + ENT_DATA_LSB +: WIDTH];
        end
    endgenerate

    assign same_hit = (SAME_CYC != 0) && write_en && (write_addr == tag);

    // Scan oldest to youngest so a younger match overwrites an older one;
    // the in-flight write, when enabled, beats everything in the history.
    always_comb begin
        hit  = 1'b0;
        data = reg_data;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit  = 1'b1;
                data = ent_data[i];
            end
        end
        if (same_hit) begin
            hit  = 1'b1;
            data = write_data;
        end
    end
endmodule

// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit: operand forwarding between register-file read and ALU.
//  clk   in   rising-edge clock
//  rst   in   asynchronous active-high reset
//  bus   slave modport of operand_bypass_unit_if: writeback, per-channel
//        reads/mode bits and stall in; registered operand / fwd_hit out.
// Holds a DEPTH-entry writeback history, forwards the youngest matching value
// per channel, applies immediate select and negate, and registers the result.
module operand_bypass_unit
    import operand_bypass_unit_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int NUM_CH   = 2,
    parameter int SAME_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_bypass_unit_if.slave  bus
);
    localparam int ENT_W = ent_w(WIDTH, ADDR_W);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [ENT_W-1:0]         hist_reg [DEPTH];
    logic [DEPTH*ENT_W-1:0]   hist_flat;
    logic [ENT_W-1:0]         new_ent;
    logic [NUM_CH*WIDTH-1:0]  operand_reg, operand_next;
    logic [NUM_CH-1:0]        fwd_hit_reg, fwd_hit_next;

    // write_en doubles as the entry's valid bit, so an idle cycle pushes an
    // invalid entry and the history keeps aging.
    assign new_ent = {bus.write_en, bus.write_addr, bus.write_data};

    // The history advances even while stalled so no writeback is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
        end else begin
            hist_reg[0] <= new_ent;
            for (int i = 1; i < DEPTH; i++) hist_reg[i] <= hist_reg[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign hist_flat[gi*ENT_W +: ENT_W] = hist_reg[gi];
        end

        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             hit_c;
            logic [WIDTH-1:0] data_c;
            logic [WIDTH-1:0] sel_c;

            bypass_lookup #(
                .WIDTH    (WIDTH),
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .SAME_CYC (SAME_CYC)
            ) u_lookup (
                .hist       (hist_flat),
                .write_en   (bus.write_en),
                .write_addr (bus.write_addr),
                .write_data (bus.write_data),
                .tag        (bus.read_addr[gi*ADDR_W +: ADDR_W]),
                .reg_data   (bus.reg_data[gi*WIDTH +: WIDTH]),
                .hit        (hit_c),
                .data       (data_c)
            );

            // Immediate channels never report a forward, even if a write to
            // the same tag is in flight.
            assign sel_c = bus.src_sel[gi] ? bus.imm[gi*WIDTH +: WIDTH] : data_c;
            assign fwd_hit_next[gi] = hit_c & ~bus.src_sel[gi];
            assign operand_next[gi*WIDTH +: WIDTH] =
                bus.neg[gi] ? (~sel_c + ONE) : sel_c;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_reg <= '0;
            fwd_hit_reg <= '0;
        end else if (!bus.stall) begin
            operand_reg <= operand_next;
            fwd_hit_reg <= fwd_hit_next;
        end
    end

    assign bus.operand = operand_reg;
    assign bus.fwd_hit = fwd_hit_reg;
endmodule
